dmux8way16_buffered: RTL and testbench

- Routes a stream of 16-bit words from one input to one of 8 output channels (a..h), selected per word by a 3-bit `sel`.
- Each channel has a 1-entry holding register and its own valid/ready handshake, so a slow consumer on one channel does not corrupt data for the others.
- It is the inverse (fan-out) of the 8-way 16-bit word mux. It is used as the write-side distributor in front of the 8-register bank, and anywhere one producer feeds 8 consumers.

---
 rtl/dmux8way16_buffered.sv | 70 +++++++
 tb/tb_dmux8way16_buffered.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmux8way16_buffered.sv
// 8-way word distributor: one producer fans out to eight channels,
// each with a single-entry holding register and valid/ready handshake.
module dmux8way16_buffered #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     e,
    output logic [WIDTH-1:0]     f,
    output logic [WIDTH-1:0]     g,
    output logic [WIDTH-1:0]     h,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0] data [8];
    logic [7:0]       full;
    logic [7:0]       wr;
    logic             accept;

    // A full channel may still take a word when its consumer drains it now.
    assign in_ready = !full[sel] || out_ready[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        wr      = '0;
        wr[sel] = accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                data[i] <= '0;
            end
            full  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr[i]) begin
                    data[i] <= in;
                    full[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    full[i] <= 1'b0;
                end
            end
            count <= count + CNT_WIDTH'(accept);
        end
    end

    assign out_valid = full;
    assign a = data[0];
    assign b = data[1];
    assign c = data[2];
    assign d = data[3];
    assign e = data[4];
    assign f = data[5];
    assign g = data[6];
    assign h = data[7];

endmodule

// File: tb/tb_dmux8way16_buffered.sv
// Directed bench for dmux8way16_buffered: vector table plus
// hand-written reset, wrap and back-pressure sequences.
module tb_dmux8way16_buffered;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] count;

    logic        in_ready4;
    logic [15:0] a4, b4, c4, d4, e4, f4, g4, h4;
    logic [7:0]  out_valid4;
    logic [3:0]  count4;

    int nchecks = 0;
    int nerrs   = 0;

    dmux8way16_buffered dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    dmux8way16_buffered #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in(in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready4),
        .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4), .g(g4), .h(h4),
        .out_valid(out_valid4), .out_ready(out_ready), .count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  sel;
        logic [15:0] din;
        logic [7:0]  ordy;
        logic        exp_rdy;
        logic [7:0]  exp_ov;
        logic [15:0] exp_dat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [15:0] chan(input logic [2:0] s);
        case (s)
            3'd0: return a;
            3'd1: return b;
            3'd2: return c;
            3'd3: return d;
            3'd4: return e;
            3'd5: return f;
            3'd6: return g;
            default: return h;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic vld, input logic [2:0] s,
                        input logic [15:0] din, input logic [7:0] ordy,
                        input logic rdy, input logic [7:0] ov,
                        input logic [15:0] dat, input logic [15:0] cnt);
        vec_t v;
        v.vld = vld; v.sel = s; v.din = din; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_dat = dat; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ov"}, 32'(out_valid), 32'h0);
        chk({name, "_cnt"}, 32'(count), 32'h0);
        chk({name, "_data"}, 32'(a | b | c | d | e | f | g | h), 32'h0);
    endtask

    initial begin
        in = '0; sel = '0; in_valid = 1'b0; out_ready = 8'hFF;
        reset = 1'b0;

        // routing sweep: each channel drains the cycle after it fills
        for (int k = 0; k < 8; k++) begin
            addv(1, 3'(k), 16'h1000 + 16'(k), 8'hFF, 1,
                 8'h01 << k, 16'h1000 + 16'(k), 16'(k + 1));
        end
        addv(0, 3'd0, 16'hDEAD, 8'hFF, 1, 8'h00, 16'h1000, 16'd8);
        // same-channel back-pressure on d
        addv(1, 3'd3, 16'hBEEF, 8'hF7, 1, 8'h08, 16'hBEEF, 16'd9);
        addv(1, 3'd3, 16'hCAFE, 8'hF7, 0, 8'h08, 16'hBEEF, 16'd9);
        addv(1, 3'd3, 16'hCAFE, 8'hF7, 0, 8'h08, 16'hBEEF, 16'd9);
        addv(1, 3'd3, 16'hCAFE, 8'hFF, 1, 8'h08, 16'hCAFE, 16'd10);
        addv(0, 3'd3, 16'h0000, 8'hFF, 1, 8'h00, 16'hCAFE, 16'd10);
        // head-of-line: h stalls, b still accepted
        addv(1, 3'd7, 16'h7777, 8'h7F, 1, 8'h80, 16'h7777, 16'd11);
        addv(1, 3'd7, 16'h8888, 8'h7F, 0, 8'h80, 16'h7777, 16'd11);
        addv(1, 3'd1, 16'h0055, 8'h7D, 1, 8'h82, 16'h0055, 16'd12);
        addv(0, 3'd7, 16'h9999, 8'h7D, 0, 8'h82, 16'h7777, 16'd12);
        addv(0, 3'd1, 16'h0000, 8'hFF, 1, 8'h00, 16'h0055, 16'd12);

        // async reset with no clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all_zero("rst_idle");
        end

        foreach (vecs[i]) begin
            in_valid  = vecs[i].vld;
            sel       = vecs[i].sel;
            in        = vecs[i].din;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(in_ready),
                32'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("v%0d_ov", i), 32'(out_valid),
                32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_dat", i), 32'(chan(vecs[i].sel)),
                32'(vecs[i].exp_dat));
            chk($sformatf("v%0d_cnt", i), 32'(count),
                32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_cnt4", i), 32'(count4),
                32'(vecs[i].exp_cnt[3:0]));
        end
        in_valid = 1'b0;

        // fill a, c, e with stalled consumers, then reset mid-cycle
        out_ready = 8'h00;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            sel = 3'(2 * k);
            in = 16'hA000 + 16'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_ov", 32'(out_valid), 32'h15);
        chk("fill_c", 32'(c), 32'hA001);
        in_valid = 1'b1;
        sel = 3'd4;
        in = 16'h4444;
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'h0);
        chk("midrst_ace", 32'(a | c | e), 32'h0);
        chk("midrst_cnt", 32'(count), 32'h0);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        chk("postrst_ov", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        sel = 3'd2;
        in = 16'h2222;
        tick();
        in_valid = 1'b0;
        chk("postrst_ov2", 32'(out_valid), 32'h04);
        chk("postrst_c", 32'(c), 32'h2222);
        chk("postrst_ae", 32'(a | e), 32'h0);
        chk("postrst_cnt", 32'(count), 32'h1);

        // counter wrap on the 4-bit instance
        reset = 1'b1;
        #1;
        reset = 1'b0;
        out_ready = 8'hFF;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            sel = 3'd0;
            in = 16'(k);
            tick();
            if (k == 14) chk("wrap15", 32'(count4), 32'd15);
            if (k == 15) chk("wrap16", 32'(count4), 32'd0);
            if (k == 16) chk("wrap17", 32'(count4), 32'd1);
        end
        in_valid = 1'b0;
        chk("wrap_cnt16", 32'(count), 32'd17);
        chk("wrap_a", 32'(a), 32'd16);
        tick();
        chk("wrap_drain", 32'(out_valid), 32'h0);
        chk("wrap_hold", 32'(a), 32'd16);
        chk("wrap_cnt_idle", 32'(count4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrs);
        $finish;
    end

endmodule
